key_search_controller: RTL

Brute-force RC4 key search controller; the initiator side of the `datapath` start/done/ack handshake. It drives successive candidate keys into `datapath` and starts each run. When a run completes, it scans decrypted D memory through a dedicated read port and acknowledges completion. It stops on the first key whose plaintext is entirely lowercase ASCII or space, or when the configured key range is exhausted. It sits between the top-level (switches, LEDs, HEX) and `datapath`.

---
 rtl/key_search_controller_if.sv | 30 +++
 rtl/key_search_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/key_search_controller_if.sv
// Handshake and D-memory read-port bundle between key_search_controller (master)
// and the RC4 datapath (slave).
interface key_search_controller_if #(
  parameter int unsigned KEY_WIDTH = 10
);
  logic [KEY_WIDTH-1:0] input_key;
  logic                 datapath_start;
  logic                 datapath_done;
  logic                 datapath_done_ack;
  logic [4:0]           d_mem_rd_addr;
  logic [7:0]           d_mem_data_read;

  modport master (
    output input_key,
    output datapath_start,
    output datapath_done_ack,
    output d_mem_rd_addr,
    input  datapath_done,
    input  d_mem_data_read
  );

  modport slave (
    input  input_key,
    input  datapath_start,
    input  datapath_done_ack,
    input  d_mem_rd_addr,
    output datapath_done,
    output d_mem_data_read
  );
endinterface

// File: rtl/key_search_controller.sv
// Brute-force RC4 key search: runs the datapath per key, scans decrypted D memory for
// lowercase/space plaintext. Optional macro KEY_SEARCH_EARLY_ABORT_EN ends a scan early.
module key_search_controller #(
  parameter int unsigned          KEY_WIDTH = 10,
  parameter int unsigned          MSG_LEN   = 32,
  parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_END   = '1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           search_start,
  key_search_controller_if.master        dp,
  output logic                           search_busy,
  output logic                           key_found,
  output logic                           key_fail
);

  localparam logic [4:0] LastAddr = 5'(MSG_LEN - 1);
  localparam logic [5:0] LastCnt  = 6'(MSG_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StStartDp,
    StWaitDp,
    StScan,
    StAckDp,
    StNextKey,
    StFound,
    StFail
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [4:0]           addr_q, addr_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 all_valid_q, all_valid_d;

  logic check_en, byte_ok, scan_last, scan_abort;
  logic dp_start, dp_ack;

  // Read data lags the address by one cycle, so scan cycle n checks byte n-1.
  assign check_en  = (state_q == StScan) && (cnt_q != 6'd0);
  assign byte_ok   = (dp.d_mem_data_read == 8'h20) ||
                     ((dp.d_mem_data_read >= 8'h61) && (dp.d_mem_data_read <= 8'h7a));
  assign scan_last = check_en && (cnt_q == LastCnt);

`ifdef KEY_SEARCH_EARLY_ABORT_EN
  assign scan_abort = check_en && !byte_ok;
`else
  assign scan_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StFound, StFail: if (search_start) state_d = StStartDp;
      StStartDp:               state_d = StWaitDp;
      StWaitDp:                if (dp.datapath_done) state_d = StScan;
      StScan:                  if (scan_last || scan_abort) state_d = StAckDp;
      StAckDp: begin
        // Compare against KEY_END before incrementing so the key never wraps.
        if (all_valid_q)          state_d = StFound;
        else if (key_q == KEY_END) state_d = StFail;
        else                       state_d = StNextKey;
      end
      StNextKey:               state_d = StStartDp;
      default:                 state_d = StIdle;
    endcase
  end

  always_comb begin
    dp_start    = 1'b0;
    dp_ack      = 1'b0;
    search_busy = 1'b1;
    key_found   = 1'b0;
    key_fail    = 1'b0;
    unique case (state_q)
      StIdle:    search_busy = 1'b0;
      StFound: begin
        search_busy = 1'b0;
        key_found   = 1'b1;
      end
      StFail: begin
        search_busy = 1'b0;
        key_fail    = 1'b1;
      end
      StStartDp: dp_start = 1'b1;
      StAckDp:   dp_ack   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    key_d       = key_q;
    addr_d      = 5'd0;
    cnt_d       = 6'd0;
    all_valid_d = all_valid_q;
    unique case (state_q)
      StIdle, StFound, StFail: if (search_start) key_d = KEY_START;
      StWaitDp:                all_valid_d = 1'b1;
      StScan: begin
        if (check_en) all_valid_d = all_valid_q & byte_ok;
        if (state_d == StScan) begin
          cnt_d  = cnt_q + 6'd1;
          addr_d = (addr_q == LastAddr) ? addr_q : addr_q + 5'd1;
        end
      end
      StNextKey:               key_d = key_q + KEY_WIDTH'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q       <= KEY_START;
      addr_q      <= 5'd0;
      cnt_q       <= 6'd0;
      all_valid_q <= 1'b0;
    end else begin
      key_q       <= key_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      all_valid_q <= all_valid_d;
    end
  end

  assign dp.input_key         = key_q;
  assign dp.d_mem_rd_addr     = addr_q;
  assign dp.datapath_start    = dp_start;
  assign dp.datapath_done_ack = dp_ack;

endmodule
